dkongjr_vram_cpuif: RTL and testbench

DKONGJR_VRAM_CPUIF -- requirements
Module: dkongjr_vram_cpuif

---
 rtl/dkongjr_pkg.sv | 24 ++
 rtl/dkongjr_wr_fifo.sv | 54 +++++
 rtl/dkongjr_vram_cpuif.sv | 147 ++++++++++++++
 tb/tb_dkongjr_vram_cpuif.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dkongjr_pkg.sv
// Shared types and constants for the Donkey Kong Jr. CPU-to-VRAM interface.
package dkongjr_pkg;

    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned AB_W_DEF       = 10;
    localparam int unsigned DB_W           = 8;

    // A posted write entry is {address, data}.
    function automatic int unsigned entry_w(input int unsigned ab_w);
        return ab_w + DB_W;
    endfunction

    typedef enum logic [2:0] {
        StIdle,
        StWrSetup,
        StWrStb,
        StWrHold,
        StRdSetup,
        StRdStb,
        StRdCap,
        StRdDone
    } drain_state_e;

endpackage

// File: rtl/dkongjr_wr_fifo.sv
// Posted-write FIFO; simultaneous push and pop is legal at any fill level.
module dkongjr_wr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FullCnt = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != FullCnt) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];
    assign full  = (count_q == FullCnt);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/dkongjr_vram_cpuif.sv
// CPU-side VRAM port: posted write FIFO, busy-gated drain FSM and waited reads.
module dkongjr_vram_cpuif
    import dkongjr_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned AB_W       = AB_W_DEF
) (
    input  logic            CLK_12M,
    input  logic            I_RSTn,
    input  logic [AB_W-1:0] I_CPU_AB,
    input  logic [7:0]      I_CPU_DB,
    input  logic            I_CPU_WRn,
    input  logic            I_CPU_RDn,
    input  logic            I_VRAMBUSYn,
    input  logic [7:0]      I_VRAM_DB,
    output logic [AB_W-1:0] O_AB,
    output logic [7:0]      O_DB,
    output logic            O_VRAM_WRn,
    output logic            O_VRAM_RDn,
    output logic [7:0]      O_CPU_DB,
    output logic            O_WAITn,
    output logic            O_FULL,
    output logic            O_OVF
);

    localparam int unsigned EW = entry_w(AB_W);

    drain_state_e state_q, state_d;

    logic                       wr_prev_q, rd_prev_q, wr_req, rd_req;
    logic                       pend_q, rd_wait_q, ovf_q;
    logic [EW-1:0]              pend_entry_q;
    logic [AB_W-1:0]            ab_q;
    logic [7:0]                 db_q, cpu_db_q;
    logic                       accept_new, pend_push, hold_new, drop;
    logic                       push, pop, load_wr, load_rd, capture;
    logic [EW-1:0]              push_data, fifo_head;
    logic                       fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign wr_req = wr_prev_q && !I_CPU_WRn;
    assign rd_req = rd_prev_q && !I_CPU_RDn;
    assign pop    = (state_q == StWrStb);

    always_comb begin
        accept_new = wr_req && !pend_q && !rd_wait_q && (!fifo_full || pop);
        pend_push  = pend_q && !rd_wait_q && (!fifo_full || pop);
        hold_new   = wr_req && !pend_q && !accept_new;
        // WRn released before a held write could be posted: the write is lost.
        drop       = pend_q && I_CPU_WRn && !pend_push;
        push       = accept_new || pend_push;
        push_data  = pend_push ? pend_entry_q : {I_CPU_AB, I_CPU_DB};
    end

    dkongjr_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_wr_fifo (
        .clk   (CLK_12M),
        .rst_n (I_RSTn),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        load_wr = 1'b0;
        load_rd = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && I_VRAMBUSYn) begin
                    state_d = StWrSetup;
                    load_wr = 1'b1;
                end else if (rd_wait_q && (fifo_count == '0) && I_VRAMBUSYn) begin
                    state_d = StRdSetup;
                    load_rd = 1'b1;
                end
            end
            StWrSetup: state_d = I_VRAMBUSYn ? StWrStb : StIdle;
            StWrStb:   state_d = StWrHold;
            StWrHold:  state_d = StIdle;
            StRdSetup: state_d = I_VRAMBUSYn ? StRdStb : StIdle;
            StRdStb:   state_d = StRdCap;
            StRdCap: begin
                state_d = StRdDone;
                capture = 1'b1;
            end
            StRdDone:  state_d = I_CPU_RDn ? StIdle : StRdDone;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK_12M or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q      <= StIdle;
            wr_prev_q    <= 1'b1;
            rd_prev_q    <= 1'b1;
            pend_q       <= 1'b0;
            pend_entry_q <= '0;
            rd_wait_q    <= 1'b0;
            ovf_q        <= 1'b0;
            ab_q         <= '0;
            db_q         <= '0;
            cpu_db_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_prev_q <= I_CPU_WRn;
            rd_prev_q <= I_CPU_RDn;
            if (hold_new) begin
                pend_q       <= 1'b1;
                pend_entry_q <= {I_CPU_AB, I_CPU_DB};
            end else if (pend_push || drop) begin
                pend_q <= 1'b0;
            end
            if (drop) ovf_q <= 1'b1;
            if (rd_req) begin
                rd_wait_q <= 1'b1;
            end else if (state_q == StRdCap) begin
                rd_wait_q <= 1'b0;
            end
            if (load_wr) begin
                ab_q <= fifo_head[EW-1:DB_W];
                db_q <= fifo_head[DB_W-1:0];
            end else if (load_rd) begin
                ab_q <= I_CPU_AB;
            end
            if (capture) cpu_db_q <= I_VRAM_DB;
        end
    end

    // Strobes decode straight from the async-reset state so reset drops them at once.
    assign O_VRAM_WRn = (state_q != StWrStb);
    assign O_VRAM_RDn = !((state_q == StRdStb) || (state_q == StRdCap));
    assign O_WAITn    = !(pend_q || rd_wait_q);
    assign O_AB       = ab_q;
    assign O_DB       = db_q;
    assign O_CPU_DB   = cpu_db_q;
    assign O_FULL     = fifo_full;
    assign O_OVF      = ovf_q;

endmodule

// File: tb/tb_dkongjr_vram_cpuif.sv
// Self-checking bench: CPU-order write queue, reference memory and latency arithmetic.
module tb_dkongjr_vram_cpuif;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] cpu_ab;
    logic [7:0] cpu_db;
    logic       cpu_wrn, cpu_rdn, busyn;
    logic [7:0] vram_db;
    logic [9:0] o_ab;
    logic [7:0] o_db, o_cpu_db;
    logic       o_vram_wrn, o_vram_rdn, o_waitn, o_full, o_ovf;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic       busy_at_pos = 1'b1;
    logic [17:0] exp_q [$];
    int         stb_hist [$];
    int         rd_first_cyc = 0;
    int         req_cyc = 0;
    int         release_cyc = 0;
    int         wr_pulses = 0;
    int         waitn_low_cnt = 0;
    bit         ovf_exp = 1'b0;
    bit         rd_active = 1'b0;
    bit         done = 1'b0;
    bit         rand_busy = 1'b0;
    logic [9:0] rd_addr_exp = '0;
    logic [7:0] vmem [1024] = '{default: 8'h00};
    logic [7:0] ref_mem [1024] = '{default: 8'h00};

    dkongjr_vram_cpuif dut (
        .CLK_12M     (clk),
        .I_RSTn      (rst_n),
        .I_CPU_AB    (cpu_ab),
        .I_CPU_DB    (cpu_db),
        .I_CPU_WRn   (cpu_wrn),
        .I_CPU_RDn   (cpu_rdn),
        .I_VRAMBUSYn (busyn),
        .I_VRAM_DB   (vram_db),
        .O_AB        (o_ab),
        .O_DB        (o_db),
        .O_VRAM_WRn  (o_vram_wrn),
        .O_VRAM_RDn  (o_vram_rdn),
        .O_CPU_DB    (o_cpu_db),
        .O_WAITn     (o_waitn),
        .O_FULL      (o_full),
        .O_OVF       (o_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        busy_at_pos <= busyn;
        if (!o_vram_wrn) vmem[o_ab] <= o_db;
    end

    assign vram_db = vmem[o_ab];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [7:0] d, input bit violate);
        int n = 0;
        cpu_ab  = a;
        cpu_db  = d;
        cpu_wrn = 1'b0;
        @(posedge clk);
        #1 req_cyc = cyc;
        if (!violate) begin
            exp_q.push_back({a, d});
            ref_mem[a] = d;
        end
        @(negedge clk);
        if (violate) begin
            chk("viol_waitn_low", int'(o_waitn), 0);
            @(posedge clk);
            #2 cpu_wrn = 1'b1;
            @(posedge clk);
            #1 ovf_exp = 1'b1;
            #1;
            return;
        end
        while (!o_waitn && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!o_waitn) chk("wr_wait_timeout", int'(o_waitn), 1);
        release_cyc = cyc;
        @(posedge clk);
        #2 cpu_wrn = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic cpu_read(input logic [9:0] a, output int lat);
        int n = 0;
        logic [7:0] expd;
        cpu_ab      = a;
        rd_addr_exp = a;
        rd_active   = 1'b1;
        cpu_rdn     = 1'b0;
        @(posedge clk);
        #1 req_cyc = cyc;
        expd = ref_mem[a];
        @(negedge clk);
        chk("rd_waitn_low", int'(o_waitn), 0);
        while (!o_waitn && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!o_waitn) chk("rd_wait_timeout", int'(o_waitn), 1);
        lat = cyc - req_cyc + 1;
        chk("rd_data", int'(o_cpu_db), int'(expd));
        @(posedge clk);
        #2 cpu_rdn = 1'b1;
        rd_active = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int p0;
        logic [9:0] ra;
        rst_n   = 1'b0;
        cpu_ab  = '0;
        cpu_db  = '0;
        cpu_wrn = 1'b1;
        cpu_rdn = 1'b1;
        busyn   = 1'b1;
        fork
            begin : monitor
                bit prev_wr_low = 1'b0;
                bit prev_rd_low = 1'b0;
                logic [17:0] e;
                while (!done) begin
                    @(negedge clk);
                    if (rst_n) begin
                        if (!o_vram_wrn) begin
                            vectors++;
                            if (prev_wr_low) begin
                                miscompares++;
                                $display("FAIL wr_pulse_width: WRn low again, expected one clock");
                            end else begin
                                wr_pulses++;
                                stb_hist.push_back(cyc);
                                if (!busy_at_pos) begin
                                    miscompares++;
                                    $display("FAIL wr_busy_gate: strobe while BUSYn=0");
                                end
                                if (exp_q.size() == 0) begin
                                    miscompares++;
                                    $display("FAIL wr_unexpected: AB=0x%0h DB=0x%0h", o_ab, o_db);
                                end else begin
                                    e = exp_q.pop_front();
                                    if ({o_ab, o_db} != e) begin
                                        miscompares++;
                                        $display("FAIL wr_data: got 0x%0h/0x%0h expected 0x%0h/0x%0h",
                                                 o_ab, o_db, e[17:8], e[7:0]);
                                    end
                                end
                            end
                        end
                        if (!o_vram_rdn) begin
                            vectors++;
                            if (!prev_rd_low) rd_first_cyc = cyc;
                            if (!rd_active || exp_q.size() != 0 || o_ab != rd_addr_exp ||
                                !o_vram_wrn || (!prev_rd_low && !busy_at_pos)) begin
                                miscompares++;
                                $display("FAIL rd_strobe: AB=0x%0h expected 0x%0h, pending writes %0d",
                                         o_ab, rd_addr_exp, exp_q.size());
                            end
                        end
                        vectors++;
                        if (o_ovf != ovf_exp) begin
                            miscompares++;
                            $display("FAIL ovf: got %0d expected %0d", o_ovf, ovf_exp);
                        end
                        if (!o_waitn) waitn_low_cnt++;
                    end
                    prev_wr_low = !o_vram_wrn;
                    prev_rd_low = !o_vram_rdn;
                end
            end
            begin : stimulus
                #1;
                chk("rst_wrn", int'(o_vram_wrn), 1);
                chk("rst_rdn", int'(o_vram_rdn), 1);
                chk("rst_waitn", int'(o_waitn), 1);
                chk("rst_full", int'(o_full), 0);
                chk("rst_ovf", int'(o_ovf), 0);
                chk("rst_ab", int'(o_ab), 0);
                chk("rst_db", int'(o_db), 0);
                chk("rst_cpu_db", int'(o_cpu_db), 0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #2;

                // Single write: strobe two clocks after the push, no wait.
                waitn_low_cnt = 0;
                stb_hist.delete();
                cpu_write(10'h3A5, 8'h5C, 1'b0);
                p0 = req_cyc;
                wait_drain();
                chk("w1_pulses", stb_hist.size(), 1);
                if (stb_hist.size() > 0) chk("w1_stb_delay", stb_hist[0] - p0, 2);
                chk("w1_waitn_never_low", waitn_low_cnt, 0);
                chk("w1_mem", int'(vmem[10'h3A5]), 8'h5C);

                // Five writes into a depth-4 FIFO with the renderer busy.
                busyn = 1'b0;
                stb_hist.delete();
                for (int i = 0; i < 4; i++) cpu_write(10'h100 + 10'(i), 8'h10 + 8'(i), 1'b0);
                @(negedge clk);
                chk("f4_full", int'(o_full), 1);
                fork
                    cpu_write(10'h104, 8'h14, 1'b0);
                    begin
                        repeat (5) @(negedge clk);
                        chk("f5_waitn_low", int'(o_waitn), 0);
                        chk("f5_full", int'(o_full), 1);
                        @(posedge clk);
                        #2 busyn = 1'b1;
                    end
                join
                wait_drain();
                chk("f5_pulses", stb_hist.size(), 5);
                if (stb_hist.size() > 0) chk("f5_release", release_cyc, stb_hist[0] + 1);
                chk("f5_ovf", int'(o_ovf), 0);
                chk("f5_not_full", int'(o_full), 0);

                // Read-after-write ordering with minimum-latency read afterwards.
                stb_hist.delete();
                cpu_write(10'h010, 8'hAA, 1'b0);
                cpu_read(10'h010, lat);
                chk("raw_data", int'(o_cpu_db), 8'hAA);
                if (stb_hist.size() > 0) chk("raw_order", int'(rd_first_cyc > stb_hist[0]), 1);
                cpu_read(10'h3A5, lat);
                chk("rd_latency", lat, 5);
                chk("rd_hold_data", int'(o_cpu_db), 8'h5C);

                // BUSYn drops during write setup: no strobe, entry retained.
                cpu_ab  = 10'h2C3;
                cpu_db  = 8'h77;
                cpu_wrn = 1'b0;
                @(posedge clk);
                #1 exp_q.push_back({10'h2C3, 8'h77});
                ref_mem[10'h2C3] = 8'h77;
                n = wr_pulses;
                @(posedge clk);
                #2 busyn = 1'b0;
                cpu_wrn = 1'b1;
                repeat (6) @(negedge clk);
                chk("abort_no_pulse", wr_pulses - n, 0);
                chk("abort_retained", exp_q.size(), 1);
                busyn = 1'b1;
                wait_drain();
                chk("abort_mem", int'(vmem[10'h2C3]), 8'h77);

                // WRn released while the write is held on a full FIFO.
                busyn = 1'b0;
                for (int i = 0; i < 4; i++) cpu_write(10'h180 + 10'(i), 8'hC0 + 8'(i), 1'b0);
                cpu_write(10'h1FF, 8'h99, 1'b1);
                repeat (3) @(negedge clk);
                chk("viol_ovf", int'(o_ovf), 1);
                busyn = 1'b1;
                wait_drain();
                chk("viol_ovf_sticky", int'(o_ovf), 1);
                chk("viol_dropped", int'(vmem[10'h1FF]), 0);

                // Reset in the middle of a read strobe.
                cpu_ab      = 10'h055;
                rd_addr_exp = 10'h055;
                rd_active   = 1'b1;
                cpu_rdn     = 1'b0;
                n = 0;
                @(negedge clk);
                while (o_vram_rdn && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("rst_reach_rdstb", int'(o_vram_rdn), 0);
                #1 rst_n = 1'b0;
                ovf_exp = 1'b0;
                exp_q.delete();
                #1;
                chk("mid_rst_rdn", int'(o_vram_rdn), 1);
                chk("mid_rst_waitn", int'(o_waitn), 1);
                chk("mid_rst_full", int'(o_full), 0);
                chk("mid_rst_ovf", int'(o_ovf), 0);
                cpu_rdn   = 1'b1;
                rd_active = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #2;
                cpu_write(10'h0F0, 8'h3C, 1'b0);
                wait_drain();
                chk("post_rst_mem", int'(vmem[10'h0F0]), 8'h3C);

                // Random mix of writes and reads against a toggling renderer grant.
                rand_busy = 1'b1;
                fork
                    begin
                        while (rand_busy) begin
                            @(posedge clk);
                            #2 busyn = ($urandom_range(0, 9) < 7);
                        end
                        busyn = 1'b1;
                    end
                    begin
                        for (int t = 0; t < 60; t++) begin
                            ra = 10'h200 + 10'($urandom_range(0, 15));
                            if ($urandom_range(0, 9) < 7) cpu_write(ra, 8'($urandom), 1'b0);
                            else cpu_read(ra, lat);
                        end
                        rand_busy = 1'b0;
                    end
                join
                wait_drain();
                for (int i = 0; i < 16; i++)
                    chk("rand_mem", int'(vmem[10'h200 + 10'(i)]), int'(ref_mem[10'h200 + 10'(i)]));
                done = 1'b1;
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
